// File: rtl/ysyx_23060096_pkg.sv
// Shared definitions for the NPC front end: fetch FSM encoding, reset PC and
// the canonical NOP word.
package ysyx_23060096_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        REQ  = ST_REQ,
        WAIT = ST_WAIT,
        HOLD = ST_HOLD
    } ifu_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [31:0] INST_NOP         = 32'h0000_0013;

    // Even parity over an instruction word, for integrity tagging downstream.
    function automatic logic inst_parity(input logic [31:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/ysyx_23060096_Reg.sv
// Generic enabled register with asynchronous active-low reset to a
// parameterised value.
module ysyx_23060096_Reg #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_r;

    // Storage element: load on enable, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r <= RESET_VAL;
        end else if (en) begin
            q_r <= d;
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/ysyx_23060096_ifu.sv
// Instruction fetch unit: owns the PC, issues one fetch at a time and holds the
// returned word for decode. Redirects flush in-flight fetches via the drop flag.
module ysyx_23060096_ifu
    import ysyx_23060096_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    ifu_state_e      state_r;
    ifu_state_e      state_s;
    logic            drop_r;
    logic            drop_s;
    logic            capture_s;
    logic            advance_s;
    logic            pc_en_s;
    logic [XLEN-1:0] pc_d_s;
    logic [XLEN-1:0] pc_q_s;
    logic [XLEN-1:0] pc_plus4_s;
    logic [XLEN-1:0] redirect_target_s;
    logic            redirect_lsb_unused_s;

    assign redirect_target_s     = {redirect_pc[XLEN-1:2], 2'b00};
    assign redirect_lsb_unused_s = ^redirect_pc[1:0];
    assign pc_plus4_s            = pc_q_s + {{(XLEN-3){1'b0}}, 3'b100};

    // FSM state and drop flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            drop_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            drop_r  <= drop_s;
        end
    end

    // Next-state, drop-flag and capture/advance decode.
    always_comb begin
        state_s   = state_r;
        drop_s    = drop_r;
        capture_s = 1'b0;
        advance_s = 1'b0;
        case (state_r)
            IDLE: begin
                state_s = REQ;
            end
            REQ: begin
                if (imem_req_ready) begin
                    state_s = WAIT;
                    drop_s  = redirect_valid;
                end else begin
                    state_s = REQ;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    // A pending or same-cycle redirect makes this response stale.
                    if (drop_r || redirect_valid) begin
                        state_s = REQ;
                        drop_s  = 1'b0;
                    end else begin
                        state_s   = HOLD;
                        capture_s = 1'b1;
                    end
                end else if (redirect_valid) begin
                    drop_s = 1'b1;
                end else begin
                    drop_s = drop_r;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    state_s = REQ;
                end else if (inst_ready) begin
                    state_s   = REQ;
                    advance_s = 1'b1;
                end else begin
                    state_s = HOLD;
                end
            end
            default: begin
                state_s = IDLE;
                drop_s  = 1'b0;
            end
        endcase
    end

    // PC update selection: redirect beats sequential advance.
    always_comb begin
        pc_en_s = 1'b0;
        pc_d_s  = pc_q_s;
        if (redirect_valid) begin
            pc_en_s = 1'b1;
            pc_d_s  = redirect_target_s;
        end else if (advance_s) begin
            pc_en_s = 1'b1;
            pc_d_s  = pc_plus4_s;
        end else begin
            pc_en_s = 1'b0;
            pc_d_s  = pc_q_s;
        end
    end

    ysyx_23060096_Reg #(
        .WIDTH     (XLEN),
        .RESET_VAL (RESET_PC)
    ) u_pc_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pc_en_s),
        .d     (pc_d_s),
        .q     (pc_q_s)
    );

    ysyx_23060096_Reg #(
        .WIDTH     (32),
        .RESET_VAL (32'h0000_0000)
    ) u_inst_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (capture_s),
        .d     (imem_rsp_data),
        .q     (inst)
    );

    ysyx_23060096_Reg #(
        .WIDTH     (XLEN),
        .RESET_VAL (RESET_PC)
    ) u_inst_pc_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (capture_s),
        .d     (pc_q_s),
        .q     (inst_pc)
    );

    assign imem_req_valid = (state_r == REQ);
    assign imem_req_addr  = pc_q_s;
    assign inst_valid     = (state_r == HOLD);

endmodule

// File: tb/tb_ysyx_23060096_ifu.sv
// Scoreboard bench for the fetch unit: stimulus pushes expected requests and
// instructions, a monitor pops and compares on each handshake.
module tb_ysyx_23060096_ifu;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
    } exp_inst_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0000_0000;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0000_0000;

    int          tests = 0;
    int          fails = 0;
    int          mem_lat = 1;
    int          mem_cnt = 0;
    logic [31:0] mem_pend = 32'h0000_0000;

    logic [31:0] exp_req_q[$];
    exp_inst_t   exp_inst_q[$];

    ysyx_23060096_ifu dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        case (addr)
            32'h8000_0000: return 32'h0010_0093;
            32'h8000_0004: return 32'h0020_0113;
            32'h8000_0008: return 32'h0030_0193;
            32'h8000_0100: return 32'h0040_0213;
            32'h8000_0040: return 32'h0050_0293;
            default:       return 32'h0000_0013;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: event did not occur", name);
    endtask

    task automatic wait_valid(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (inst_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) fail_now(name);
    endtask

    // Memory model: responds mem_lat cycles after an accepted request.
    always @(negedge clk) begin
        #4;
        imem_rsp_valid = 1'b0;
        if (mem_cnt > 0) begin
            mem_cnt = mem_cnt - 1;
            if (mem_cnt == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(mem_pend);
            end
        end
        if (imem_req_valid === 1'b1 && imem_req_ready === 1'b1) begin
            mem_pend = imem_req_addr;
            mem_cnt  = mem_lat;
        end
    end

    // Monitor: compares requests and presented instructions against the queues.
    always @(negedge clk) begin
        #4;
        if (rst_n === 1'b1) begin
            if (imem_req_valid === 1'b1 && imem_req_ready === 1'b1) begin
                if (exp_req_q.size() == 0) fail_now("unexpected_req");
                else check("req_addr", imem_req_addr, exp_req_q.pop_front());
            end
            if (inst_valid === 1'b1) begin
                check("no_req_in_hold", {31'd0, imem_req_valid}, 32'd0);
                if (exp_inst_q.size() == 0) begin
                    fail_now("unexpected_inst");
                end else begin
                    check("inst_word", inst, exp_inst_q[0].word);
                    check("inst_pc", inst_pc, exp_inst_q[0].pc);
                    if (inst_ready === 1'b1) void'(exp_inst_q.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("rst_req_addr", imem_req_addr, 32'h8000_0000);
        check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_inst", inst, 32'h0000_0000);
        check("rst_inst_pc", inst_pc, 32'h8000_0000);

        // First fetch with zero-wait memory, then decode backpressure.
        exp_req_q.push_back(32'h8000_0000);
        exp_inst_q.push_back('{32'h0010_0093, 32'h8000_0000});
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("first_hold_early", {31'd0, inst_valid}, 32'd0);
        @(negedge clk);
        check("first_hold_time", {31'd0, inst_valid}, 32'd1);
        repeat (5) @(negedge clk);

        // Release decode with memory stalled; request follows one cycle later.
        imem_req_ready = 1'b0;
        exp_req_q.push_back(32'h8000_0004);
        inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
        check("req_after_ready", {31'd0, imem_req_valid}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("stall_req_valid", {31'd0, imem_req_valid}, 32'd1);
            check("stall_req_addr", imem_req_addr, 32'h8000_0004);
            @(negedge clk);
        end
        mem_lat = 4;
        exp_inst_q.push_back('{32'h0020_0113, 32'h8000_0004});
        exp_req_q.push_back(32'h8000_0008);
        imem_req_ready = 1'b1;
        inst_ready = 1'b1;
        wait_valid("stall_deliver");

        // Redirect while waiting: stale word for 8000_0008 must be dropped.
        mem_lat = 3;
        @(negedge clk);
        @(negedge clk);
        check("wait_state_no_req", {31'd0, imem_req_valid}, 32'd0);
        exp_req_q.push_back(32'h8000_0100);
        exp_inst_q.push_back('{32'h0040_0213, 32'h8000_0100});
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_0103;
        @(negedge clk);
        redirect_valid = 1'b0;
        inst_ready = 1'b0;
        mem_lat = 1;
        wait_valid("redirect_wait_deliver");

        // Redirect and decode accept in the same HOLD cycle.
        exp_req_q.push_back(32'h8000_0040);
        exp_inst_q.push_back('{32'h0050_0293, 32'h8000_0040});
        inst_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_0040;
        @(negedge clk);
        redirect_valid = 1'b0;
        check("hold_redirect_valid", {31'd0, imem_req_valid}, 32'd1);
        check("hold_redirect_addr", imem_req_addr, 32'h8000_0040);
        exp_req_q.push_back(32'h8000_0044);
        wait_valid("hold_redirect_deliver");

        // Asynchronous reset pulse while waiting on a slow response.
        mem_lat = 3;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("async_req_addr", imem_req_addr, 32'h8000_0000);
        check("async_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("async_inst", inst, 32'h0000_0000);
        check("async_inst_pc", inst_pc, 32'h8000_0000);
        exp_req_q.push_back(32'h8000_0000);
        exp_inst_q.push_back('{32'h0010_0093, 32'h8000_0000});
        @(negedge clk);
        rst_n = 1'b1;
        wait_valid("after_reset_deliver");
        imem_req_ready = 1'b0;
        repeat (4) @(negedge clk);

        check("req_queue_empty", exp_req_q.size(), 32'd0);
        check("inst_queue_empty", exp_inst_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ysyx_23060096_ifu.md
# ysyx_23060096_ifu

Instruction fetch unit for the NPC core. It owns the PC, issues one word-aligned fetch at a time on a valid/ready instruction-memory port, and holds the returned instruction word for the decode stage (`ysyx_23060096_ContrGen`). That decode stage consumes `inst[6:0]`, `inst[14:12]` and `inst[31:25]` as `op`, `func3` and `func7`. Branch and jump redirects from execute flush any fetch in flight.

## Interface
Parameters:
- `XLEN`, 32: address and instruction width.
- `RESET_PC`, 32'h8000_0000: PC after reset.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_req_addr`  out  XLEN  fetch address, always equal to the PC.
- `imem_rsp_valid`  in  1  response valid, single-cycle pulse; no backpressure.
- `imem_rsp_data`  in  32  fetched instruction word.
- `inst_valid`  out  1  instruction available to decode.
- `inst_ready`  in  1  decode accepts instruction.
- `inst`  out  32  held instruction word.
- `inst_pc`  out  XLEN  PC of `inst`.
- `redirect_valid`  in  1  branch/jump taken.
- `redirect_pc`  in  XLEN  target; bits [1:0] are ignored and treated as 0.

## Operation
- FSM states:
  - IDLE: reset state.
  - REQ: `imem_req_valid`=1.
  - WAIT: awaiting response.
  - HOLD: `inst_valid`=1.
- IDLE always moves to REQ on the next cycle.
- REQ: on `imem_req_valid & imem_req_ready`, move to WAIT.
- WAIT: on `imem_rsp_valid`, capture `inst`=`imem_rsp_data` and `inst_pc`=PC, then move to HOLD. If the `drop` flag is set, discard the response, clear `drop` and move to REQ instead.
- HOLD: on `inst_valid & inst_ready`, set PC=PC+4 (mod 2^XLEN, wraps silently) and move to REQ.
- Redirect takes priority over all other PC updates; the PC loads `{redirect_pc[XLEN-1:2],2'b00}`.
  - In REQ without a handshake: stay in REQ; the address changes next cycle.
  - In REQ with a handshake in the same cycle: move to WAIT with `drop`=1.
  - In WAIT: set `drop`=1 and stay in WAIT. If `imem_rsp_valid` arrives in the same cycle, discard it and move to REQ.
  - In HOLD: drop the held word and move to REQ. If `inst_ready` is high in the same cycle, the word counts as delivered, but the PC still takes `redirect_pc`, not PC+4.
- `imem_rsp_valid` outside WAIT is ignored.
- At most one request is outstanding.
- `drop` guarantees that a stale response never reaches decode.

## Timing
- Reset values, applied immediately while `rst_n`=0:
  - state=IDLE, PC=`RESET_PC`, `drop`=0.
  - `imem_req_valid`=0, `imem_req_addr`=`RESET_PC`.
  - `inst_valid`=0, `inst`=0, `inst_pc`=`RESET_PC`.
- Reset asserted mid-operation abandons any outstanding request. The memory side must tolerate this.
- All outputs are registered or decoded directly from state/PC; there is no combinational path from inputs to outputs.
- Zero-wait memory (`imem_req_ready`=1, response one cycle after the request), first fetch after reset release at edge E:
  - E+1: REQ.
  - E+2: WAIT, response arrives.
  - E+3: HOLD, `inst_valid`=1.
- Steady-state throughput is 1 instruction per 3 cycles with `inst_ready`=1.
- Redirect-to-request latency:
  - Redirect in REQ, HOLD, or WAIT with a same-cycle response: 1 cycle.
  - Redirect in WAIT without a response: until the stale response returns, plus 1 cycle.
- `inst`/`inst_pc` stay stable while `inst_valid`=1 and `inst_ready`=0.

## Structure
- Shared package `ysyx_23060096_pkg` holds:
  - FSM state localparams (2-bit: IDLE=0, REQ=1, WAIT=2, HOLD=3).
  - `RESET_PC` default.
  - `INST_NOP`=32'h0000_0013.
- Sub-module `ysyx_23060096_Reg`: generic width/reset-value register with enable and async active-low reset. It is instantiated for the PC and for the `inst`/`inst_pc` holding registers.
- The FSM and `drop` flag live in the top module.

## Test plan
- Reset release, zero-wait memory returning 32'h0010_0093:
  - First `imem_req_addr`=32'h8000_0000.
  - `inst_valid` at E+3 with `inst`=32'h0010_0093 and `inst_pc`=32'h8000_0000.
  - Next request address is 32'h8000_0004.
- Decode backpressure: `inst_ready`=0 for 5 cycles in HOLD.
  - `inst` and `inst_pc` stay constant.
  - No new request is issued.
  - The request issues 1 cycle after `inst_ready`=1.
- Memory stalls: `imem_req_ready`=0 for 3 cycles, then response latency 4.
  - `imem_req_valid` stays high with a stable address.
  - Exactly one instruction is delivered.
- Redirect in WAIT to 32'h8000_0103:
  - The stale response is discarded, with no `inst_valid`.
  - The next request address is 32'h8000_0100.
- Redirect and `inst_ready` in the same HOLD cycle to 32'h8000_0040:
  - The instruction counts as delivered.
  - The next fetch address is 32'h8000_0040, not PC+4.
- `rst_n` pulsed low in WAIT:
  - Outputs return to their reset values asynchronously.
  - After release, the fetch restarts at `RESET_PC`.
  - A late `imem_rsp_valid` arriving while in IDLE or REQ is ignored.
